mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 bit-select datapath between four requesters (e.g. the two player input paths, the board-scan logic and the win-check logic). It resolves contention on a 4-bit request vector, drives the 2-bit mux select and a one-hot grant, and registers the selected data bit with a valid strobe. It sits between the requesting blocks and the 4-to-1 mux, and it includes the 4:1 selection of the data bit internally so the select and its data stay cycle-aligned.

---
 rtl/mux_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter for a shared 4-to-1 bit-select mux. It takes a 4-bit
// request vector and drives a registered one-hot grant and a binary select.
// It also registers the selected data bit with a valid strobe, so the select
// and its data stay cycle-aligned.
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to cap a grant at HOLD_MAX
// consecutive cycles while other requesters are waiting. Without the macro
// there is no hold counter, and a grant lasts until its own request drops.

module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4              // 1..15, used only with MUX_ARB_TIMEOUT_EN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_inputs,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       data_out,
    output logic       data_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last;          // most recent winner; the search starts just above it
    logic [1:0] rr_idx;        // nearest pending requester above last, excluding last
    logic       rr_found;
    logic [1:0] idle_idx;      // IDLE winner: last itself only wraps in at the end
    logic       timed_out;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [3:0] hold_cnt;      // cycles held minus one; never exceeds HOLD_MAX-1

    // Timeout fires on the edge that would start cycle HOLD_MAX+1 of the grant
    assign timed_out = (hold_cnt == 4'(HOLD_MAX - 1));
`else
    // No timeout in this build. The comparison is always false because
    // HOLD_MAX is at least 1.
    assign timed_out = (HOLD_MAX == 0);
`endif

    // Round-robin search over offsets 1..3 from last. The loop runs downward
    // so the nearest candidate is written last and wins.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred
        rr_found = 1'b0;
        rr_idx   = last;
        for (int k = 3; k >= 1; k--) begin
            if (req[last + k[1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = last + k[1:0];
            end
        end
    end

    // From IDLE, the previous holder is also eligible, as the last choice
    assign idle_idx = rr_found ? rr_idx : last;

    // Arbitration state, registered grant/select/busy, and the data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 2'd3;
            grant      <= 4'b0000;
            select     <= 2'd0;
            busy       <= 1'b0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt   <= 4'd0;
`endif
        end else begin
            // Each GRANT cycle samples the bit chosen by the current select
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values
            if (state == GRANT) begin
                data_out   <= data_inputs[select];
                data_valid <= 1'b1;
            end else begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state  <= GRANT;
                        busy   <= 1'b1;
                        grant  <= 4'b0001 << idle_idx;
                        select <= idle_idx;
                        last   <= idle_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                        hold_cnt <= 4'd0;
`endif
                    end
                end

                GRANT: begin
                    if (req[last] && !timed_out) begin
`ifdef MUX_ARB_TIMEOUT_EN
                        hold_cnt <= hold_cnt + 4'd1;
`endif
                    end else if (rr_found) begin
                        // Hand off on the same edge, so there is no idle bubble
                        grant  <= 4'b0001 << rr_idx;
                        select <= rr_idx;
                        last   <= rr_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                        hold_cnt <= 4'd0;
`endif
`ifdef MUX_ARB_TIMEOUT_EN
                    end else if (req[last]) begin
                        // Timed out with nobody waiting: keep the grant and restart the count
                        hold_cnt <= 4'd0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        grant <= 4'b0000;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios plus randomized traffic,
// checked against a holder/tenure reference model.
// The timeout checks follow MUX_ARB_TIMEOUT_EN, the same macro as the DUT.

module tb_mux_rr_arbiter;

    localparam int HOLD_MAX = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] data_inputs = 4'b0000;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       data_out;
    logic       data_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the mux, how long their current tenure has
    // run, and who was served last
    int         m_holder;   // -1 when idle
    int         m_held;     // cycles in the current tenure
    int         m_last;
    logic [1:0] m_sel;
    logic       m_dout;
    logic       m_valid;

    mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data_inputs (data_inputs),
        .grant       (grant),
        .select      (select),
        .busy        (busy),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_holder = -1;
        m_held   = 0;
        m_last   = 3;
        m_sel    = 2'd0;
        m_dout   = 1'b0;
        m_valid  = 1'b0;
    endfunction

    // First requester in r, scanning span steps upward from 'from' with wrap
    function automatic int pick(input logic [3:0] r, input int from, input int span);
        for (int k = 1; k <= span; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        int others;
        bit expired;
        if (m_holder >= 0) begin
            m_dout  = d[m_holder];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_holder < 0) begin
            others = pick(r, m_last, 4);
            if (others >= 0) begin
                m_holder = others;
                m_last   = others;
                m_held   = 1;
            end
        end else begin
            others  = pick(r, m_holder, 3);
            expired = TO_EN && (m_held == HOLD_MAX);
            if (r[m_holder] && !expired) begin
                m_held++;
            end else if (others >= 0) begin
                m_holder = others;
                m_last   = others;
                m_held   = 1;
            end else if (r[m_holder]) begin
                m_held = 1;
            end else begin
                m_holder = -1;
            end
        end
        if (m_holder >= 0) m_sel = 2'(m_holder);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".grant"},  32'(grant),      (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
        check({tag, ".select"}, 32'(select),     32'(m_sel));
        check({tag, ".busy"},   32'(busy),       32'(m_holder >= 0));
        check({tag, ".dout"},   32'(data_out),   32'(m_dout));
        check({tag, ".valid"},  32'(data_valid), 32'(m_valid));
    endtask

    // Called at a negedge; applies the inputs for one rising edge, then checks
    task automatic cycle(input logic [3:0] r, input logic [3:0] d, input string tag);
        req         = r;
        data_inputs = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        check("reset.grant0", 32'(grant), 32'd0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rq;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester, then release
        cycle(4'b0100, 4'b0100, "single");
        check("single.grant", 32'(grant), 32'h4);
        check("single.select", 32'(select), 32'd2);
        cycle(4'b0100, 4'b0100, "single_d");
        check("single.dout", 32'({data_valid, data_out}), 32'h3);
        cycle(4'b0000, 4'b0000, "release");
        check("release.grant", 32'(grant), 32'h0);
        cycle(4'b0000, 4'b0000, "release2");
        check("release.valid", 32'(data_valid), 32'h0);

        // Reset in the middle of a grant, then all four requesting
        cycle(4'b0100, 4'($urandom), "pre_rst");
        check("pre_rst.grant", 32'(grant), 32'h4);
        #2;
        do_reset();
        cycle(4'b1111, 4'($urandom), "post_rst");
        check("post_rst.grant", 32'(grant), 32'h1);

        // Requester 1 releases while requester 3 waits: direct handoff
        do_reset();
        cycle(4'b0010, 4'($urandom), "ho_a");
        cycle(4'b1001, 4'($urandom), "ho_b");
        check("handoff.grant", 32'(grant), 32'h8);
        check("handoff.busy", 32'(busy), 32'h1);

        // A lone requester keeps the grant
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0010, 4'($urandom), "lone");
            check("lone.grant", 32'(grant), 32'h2);
        end

`ifdef MUX_ARB_TIMEOUT_EN
        // Full contention: each requester holds the grant for HOLD_MAX cycles in turn
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(4'b1111, 4'($urandom), "rr");
            check("rr.grant", 32'(grant), 32'd1 << ((k / HOLD_MAX) % 4));
        end
`else
        // No timeout: requester 0 keeps the grant until it lets go
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(4'b0011, 4'($urandom), "noto");
            check("noto.grant", 32'(grant), 32'h1);
        end
        cycle(4'b0010, 4'($urandom), "noto_rel");
        check("noto_rel.grant", 32'(grant), 32'h2);
`endif

        // Randomized traffic: the request vector changes now and then
        do_reset();
        rq = 4'($urandom);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            cycle(rq, 4'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
